// File: rtl/vc_mem_msgs_pkg.sv
// Shared memory-message definitions for the vc test memories.
//
// Request message layout (MSB..LSB): {type[2:0], opaque, addr, len, data}
// Response message layout (MSB..LSB): {type[2:0], opaque, len, data}
//
// The *_FIELD macros give the LSB offset of each field within the message;
// the *_NBITS macros give field or total message widths.  They are macros
// rather than package functions so they can size parameterised ports.

`ifndef VC_MEM_MSGS_PKG_SV
`define VC_MEM_MSGS_PKG_SV

`define VC_MEM_REQ_MSG_TYPE_NBITS 3
`define VC_MEM_REQ_MSG_LEN_NBITS(d) ($clog2((d) / 8))
`define VC_MEM_REQ_MSG_DATA_FIELD 0
`define VC_MEM_REQ_MSG_LEN_FIELD(d) (d)
`define VC_MEM_REQ_MSG_ADDR_FIELD(d) ((d) + `VC_MEM_REQ_MSG_LEN_NBITS(d))
`define VC_MEM_REQ_MSG_OPAQUE_FIELD(a, d) (`VC_MEM_REQ_MSG_ADDR_FIELD(d) + (a))
`define VC_MEM_REQ_MSG_TYPE_FIELD(o, a, d) (`VC_MEM_REQ_MSG_OPAQUE_FIELD(a, d) + (o))
`define VC_MEM_REQ_MSG_NBITS(o, a, d) (`VC_MEM_REQ_MSG_TYPE_FIELD(o, a, d) + 3)

`define VC_MEM_RESP_MSG_TYPE_NBITS 3
`define VC_MEM_RESP_MSG_LEN_NBITS(d) ($clog2((d) / 8))
`define VC_MEM_RESP_MSG_DATA_FIELD 0
`define VC_MEM_RESP_MSG_LEN_FIELD(d) (d)
`define VC_MEM_RESP_MSG_OPAQUE_FIELD(d) ((d) + `VC_MEM_RESP_MSG_LEN_NBITS(d))
`define VC_MEM_RESP_MSG_TYPE_FIELD(o, d) (`VC_MEM_RESP_MSG_OPAQUE_FIELD(d) + (o))
`define VC_MEM_RESP_MSG_NBITS(o, d) (`VC_MEM_RESP_MSG_TYPE_FIELD(o, d) + 3)

package vc_mem_msgs_pkg;

  // Request/response type encodings; 6 and 7 are unassigned and decode as READ.
  typedef enum logic [2:0] {
    MEM_READ       = 3'd0,
    MEM_WRITE      = 3'd1,
    MEM_WRITE_INIT = 3'd2,
    MEM_AMO_ADD    = 3'd3,
    MEM_AMO_AND    = 3'd4,
    MEM_AMO_OR     = 3'd5
  } mem_type_e;

  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  // Galois toggle mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

`endif

// File: rtl/vc_test_mem_1port_core.sv
// Byte-addressed behavioural memory array with request decode and AMO datapath.
//
// Ports:
//   clk        clock; array updates on posedge
//   mem_clear  while high at posedge, every byte is cleared
//   req_go     request accepted this cycle (writes/AMOs commit at this edge)
//   req_type   request type (see vc_mem_msgs_pkg)
//   req_addr   byte address; only addr mod p_mem_nbytes is used
//   req_len    byte count, 0 = full word
//   req_data   write data / AMO operand
//   resp_data  response data, combinational from the pre-write array contents
//
// Build option VC_TEST_RAND_DELAY_MEM_XCLEAR_EN: clear fills with X and a READ
// touching an X byte prints a warning. Without it, clear fills with zero.

module vc_test_mem_1port_core
  import vc_mem_msgs_pkg::*;
#(
  parameter int p_mem_nbytes = 1024,
  parameter int p_addr_nbits = 32,
  parameter int p_data_nbits = 32,
  localparam int c_len_nbits = `VC_MEM_REQ_MSG_LEN_NBITS(p_data_nbits)
) (
  input  logic                    clk,
  input  logic                    mem_clear,
  input  logic                    req_go,
  input  logic [2:0]              req_type,
  input  logic [p_addr_nbits-1:0] req_addr,
  input  logic [c_len_nbits-1:0]  req_len,
  input  logic [p_data_nbits-1:0] req_data,
  output logic [p_data_nbits-1:0] resp_data
);

  localparam int c_word_nbytes = p_data_nbits / 8;
  localparam int c_idx_nbits   = $clog2(p_mem_nbytes);
  localparam int c_cnt_nbits   = c_len_nbits + 1;

`ifdef VC_TEST_RAND_DELAY_MEM_XCLEAR_EN
  localparam logic [7:0] c_clear_byte = 8'hxx;
`else
  localparam logic [7:0] c_clear_byte = 8'h00;
`endif

  logic [7:0]              mem [p_mem_nbytes];
  logic [c_idx_nbits-1:0]  base_idx;
  logic [c_idx_nbits-1:0]  byte_idx [c_word_nbytes];
  logic [c_word_nbytes-1:0] byte_en;
  logic [p_data_nbits-1:0] byte_mask;
  logic [p_data_nbits-1:0] old_word;
  logic [p_data_nbits-1:0] amo_word;
  logic [p_data_nbits-1:0] wr_word;
  logic [c_cnt_nbits-1:0]  nbytes;
  logic                    is_write;
  logic                    is_amo;
  logic                    mem_we;

  // Power-of-two array: the low address bits are the byte index, so higher
  // addresses alias onto the same bytes.
  assign base_idx = req_addr[c_idx_nbits-1:0];

  generate
    if (p_addr_nbits > c_idx_nbits) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[p_addr_nbits-1:c_idx_nbits];
    end
  endgenerate

  assign is_write = (req_type == MEM_WRITE) || (req_type == MEM_WRITE_INIT);
  assign is_amo   = (req_type == MEM_AMO_ADD) || (req_type == MEM_AMO_AND) ||
                    (req_type == MEM_AMO_OR);
  assign mem_we   = req_go && (is_write || is_amo);

  // AMOs always operate on the full word regardless of len
  assign nbytes = (is_amo || (req_len == '0)) ? c_cnt_nbits'(c_word_nbytes)
                                              : {1'b0, req_len};

  // Per-byte lanes; the index wraps naturally at the array size.
  genvar gi;
  generate
    for (gi = 0; gi < c_word_nbytes; gi++) begin : g_lane
      assign byte_idx[gi]            = base_idx + c_idx_nbits'(gi);
      assign byte_en[gi]             = c_cnt_nbits'(gi) < nbytes;
      assign byte_mask[8*gi +: 8]    = {8{byte_en[gi]}};
      assign old_word[8*gi +: 8]     = mem[byte_idx[gi]];
    end
  endgenerate

  always_comb begin
    case (req_type)
      MEM_AMO_ADD: amo_word = old_word + req_data;
      MEM_AMO_AND: amo_word = old_word & req_data;
      MEM_AMO_OR:  amo_word = old_word | req_data;
      default:     amo_word = old_word;
    endcase
  end

  assign wr_word = is_amo ? amo_word : req_data;

  always_comb begin
    if (is_amo)        resp_data = old_word;
    else if (is_write) resp_data = '0;
    else               resp_data = old_word & byte_mask;
  end

  // Clear has priority over any write committing at the same edge.
  always_ff @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < p_mem_nbytes; i++) mem[i] <= c_clear_byte;
    end else if (mem_we) begin
      for (int i = 0; i < c_word_nbytes; i++)
        if (byte_en[i]) mem[byte_idx[i]] <= wr_word[8*i +: 8];
    end
  end

`ifdef VC_TEST_RAND_DELAY_MEM_XCLEAR_EN
  always_ff @(posedge clk) begin
    if (req_go && !is_write && !is_amo && $isunknown(old_word & byte_mask))
      $display("vc_test_mem_1port_core: warning: READ of uninitialised byte, index %0d",
               base_idx);
  end
`endif

endmodule

// File: rtl/vc_test_rand_delay_mem_1port.sv
// Single-port test memory returning each response after a pseudo-random
// delay of 0..max_delay cycles, to stress val/rdy handshakes in unit benches.
//
// Ports:
//   clk, reset    clock; asynchronous active-high reset (handshake/delay state only)
//   mem_clear     synchronous memory clear
//   max_delay     upper bound of the response delay in cycles
//   memreq_*      request stream  {type, opaque, addr, len, data}
//   memresp_*     response stream {type, opaque, len, data}
//
// Build option VC_TEST_RAND_DELAY_MEM_XCLEAR_EN selects X-fill on clear
// (see vc_test_mem_1port_core).

module vc_test_rand_delay_mem_1port
  import vc_mem_msgs_pkg::*;
#(
  parameter int p_mem_nbytes   = 1024,
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  localparam int c_len_nbits  = `VC_MEM_REQ_MSG_LEN_NBITS(p_data_nbits),
  localparam int c_req_nbits  = `VC_MEM_REQ_MSG_NBITS(p_opaque_nbits, p_addr_nbits, p_data_nbits),
  localparam int c_resp_nbits = `VC_MEM_RESP_MSG_NBITS(p_opaque_nbits, p_data_nbits)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_clear,
  input  logic [31:0]             max_delay,
  input  logic                    memreq_val,
  output logic                    memreq_rdy,
  input  logic [c_req_nbits-1:0]  memreq_msg,
  output logic                    memresp_val,
  input  logic                    memresp_rdy,
  output logic [c_resp_nbits-1:0] memresp_msg
);

  logic [2:0]                req_type;
  logic [p_opaque_nbits-1:0] req_opaque;
  logic [p_addr_nbits-1:0]   req_addr;
  logic [c_len_nbits-1:0]    req_len;
  logic [p_data_nbits-1:0]   req_data;
  logic [p_data_nbits-1:0]   core_resp_data;

  logic                      resp_val_reg;
  logic [c_resp_nbits-1:0]   resp_msg_reg;
  logic [31:0]               delay_reg;
  logic [31:0]               delay_load;
  logic [31:0]               lfsr_reg;
  logic [31:0]               lfsr_next;
  logic                      req_go;
  logic                      resp_go;

  assign req_type   = memreq_msg[`VC_MEM_REQ_MSG_TYPE_FIELD(p_opaque_nbits, p_addr_nbits, p_data_nbits) +: 3];
  assign req_opaque = memreq_msg[`VC_MEM_REQ_MSG_OPAQUE_FIELD(p_addr_nbits, p_data_nbits) +: p_opaque_nbits];
  assign req_addr   = memreq_msg[`VC_MEM_REQ_MSG_ADDR_FIELD(p_data_nbits) +: p_addr_nbits];
  assign req_len    = memreq_msg[`VC_MEM_REQ_MSG_LEN_FIELD(p_data_nbits) +: c_len_nbits];
  assign req_data   = memreq_msg[`VC_MEM_REQ_MSG_DATA_FIELD +: p_data_nbits];

  // Response is only presented once its delay has run out.
  assign memresp_val = resp_val_reg && (delay_reg == '0);
  assign memresp_msg = resp_msg_reg;
  assign resp_go     = memresp_val && memresp_rdy;

  // Accept when the response slot is free or being drained this cycle;
  // held low throughout reset.
  assign memreq_rdy = !reset && (!resp_val_reg || resp_go);
  assign req_go     = memreq_val && memreq_rdy;

  assign lfsr_next  = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 32'h0);

  // max_delay = all ones would overflow max_delay+1; any 32-bit LFSR value
  // is already in range then.
  assign delay_load = (&max_delay) ? lfsr_reg : (lfsr_reg % (max_delay + 32'd1));

  vc_test_mem_1port_core #(
    .p_mem_nbytes (p_mem_nbytes),
    .p_addr_nbits (p_addr_nbits),
    .p_data_nbits (p_data_nbits)
  ) u_core (
    .clk       (clk),
    .mem_clear (mem_clear),
    .req_go    (req_go),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_data  (req_data),
    .resp_data (core_resp_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_val_reg <= 1'b0;
      delay_reg    <= '0;
      lfsr_reg     <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
      if (req_go) begin
        resp_val_reg <= 1'b1;
        delay_reg    <= delay_load;
      end else begin
        if (resp_go)            resp_val_reg <= 1'b0;
        if (delay_reg != '0)    delay_reg    <= delay_reg - 32'd1;
      end
    end
  end

  // Payload only changes on accept, so it holds while the sink stalls.
  always_ff @(posedge clk) begin
    if (req_go) resp_msg_reg <= {req_type, req_opaque, req_len, core_resp_data};
  end

  // Compact handshake snapshot for trace printing by an enclosing bench.
  task automatic trace_module(output logic [3:0] trace);
    trace = {memreq_val, memreq_rdy, memresp_val, memresp_rdy};
  endtask

endmodule

// File: tb/tb_vc_test_rand_delay_mem_1port.sv
module tb_vc_test_rand_delay_mem_1port;

  localparam int NREQ = 24;
  localparam logic [2:0] T_RD  = 3'd0;
  localparam logic [2:0] T_WR  = 3'd1;
  localparam logic [2:0] T_WN  = 3'd2;
  localparam logic [2:0] T_ADD = 3'd3;
  localparam logic [2:0] T_AND = 3'd4;
  localparam logic [2:0] T_OR  = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_clear;
  logic [31:0] max_delay;
  logic        memreq_val;
  logic        memreq_rdy;
  logic [76:0] memreq_msg;
  logic        memresp_val;
  logic        memresp_rdy;
  logic [44:0] memresp_msg;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  vc_test_rand_delay_mem_1port dut (
    .clk         (clk),
    .reset       (reset),
    .mem_clear   (mem_clear),
    .max_delay   (max_delay),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memreq_msg  (memreq_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .memresp_msg (memresp_msg)
  );

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [NREQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [2:0] t, input logic [31:0] a,
                         input logic [1:0] l, input logic [31:0] d, input logic [31:0] e);
    vecs[i].typ = t; vecs[i].addr = a; vecs[i].len = l; vecs[i].data = d; vecs[i].exp = e;
  endtask

  function automatic logic [44:0] exp_resp(input int i);
    return {vecs[i].typ, 8'(i), vecs[i].len, vecs[i].exp};
  endfunction

  task automatic source(input int sd);
    int w, guard;
    logic fired;
    for (int i = 0; i < NREQ; i++) begin
      memreq_val = 1'b0;
      w = $urandom_range(sd, 0);
      repeat (w) begin @(posedge clk); #1; end
      memreq_val = 1'b1;
      memreq_msg = {vecs[i].typ, 8'(i), vecs[i].addr, vecs[i].len, vecs[i].data};
      fired = 1'b0; guard = 0;
      while (!fired && guard < 1000) begin
        @(negedge clk); fired = memreq_rdy;
        @(posedge clk); #1; guard++;
      end
      check($sformatf("src_accept%0d", i), 64'(fired), 64'd1);
      if (!fired) break;
    end
    memreq_val = 1'b0;
  endtask

  task automatic sink(input int kd);
    int k, w, guard;
    logic got;
    k = 0; guard = 0;
    while (k < NREQ && guard < 2000) begin
      memresp_rdy = 1'b0;
      w = $urandom_range(kd, 0);
      repeat (w) begin @(posedge clk); #1; guard++; end
      memresp_rdy = 1'b1; got = 1'b0;
      while (!got && guard < 2000) begin
        @(negedge clk);
        if (memresp_val) begin
          check($sformatf("resp%0d", k), 64'(memresp_msg), 64'(exp_resp(k)));
          got = 1'b1; k++;
        end
        @(posedge clk); #1; guard++;
      end
    end
    memresp_rdy = 1'b0;
    check("resp_count", 64'(k), 64'(NREQ));
  endtask

  task automatic run_cfg(input int sd, input int md, input int kd, output int dur);
    int start;
    max_delay = 32'(md);
    start = cycle;
    fork
      source(sd);
      sink(kd);
    join
    dur = cycle - start;
    $display("run src=%0d mem=%0d sink=%0d: %0d cycles", sd, md, kd, dur);
    check($sformatf("cycles_%0d_%0d_%0d_lt500", sd, md, kd), 64'(dur < 500), 64'd1);
  endtask

  // One request with a ready sink; checks the whole response message.
  task automatic xact(input logic [76:0] req, input logic [44:0] exp, input string name);
    int guard;
    logic fired, got;
    logic [44:0] cap;
    memresp_rdy = 1'b1;
    memreq_val = 1'b1; memreq_msg = req;
    fired = 1'b0; guard = 0;
    while (!fired && guard < 100) begin
      @(negedge clk); fired = memreq_rdy;
      @(posedge clk); #1; guard++;
    end
    memreq_val = 1'b0;
    got = 1'b0; guard = 0; cap = 'x;
    while (!got && guard < 100) begin
      @(negedge clk);
      if (memresp_val) begin got = 1'b1; cap = memresp_msg; end
      @(posedge clk); #1; guard++;
    end
    $display("xact %s: resp %h", name, cap);
    check({name, "_resp"}, 64'(cap), 64'(exp));
  endtask

  initial begin
    int dur, lat;

    set_vec( 0, T_WR,  32'h0000, 2'd0, 32'h0a0b0c0d, 32'h0);
    set_vec( 1, T_WN,  32'h0004, 2'd0, 32'h0e0f0102, 32'h0);
    set_vec( 2, T_RD,  32'h0000, 2'd0, 32'h0,        32'h0a0b0c0d);
    set_vec( 3, T_RD,  32'h0004, 2'd0, 32'h0,        32'h0e0f0102);
    set_vec( 4, T_WR,  32'h0008, 2'd0, 32'h0a0b0c0d, 32'h0);
    set_vec( 5, T_WR,  32'h0008, 2'd1, 32'hdeadbeef, 32'h0);
    set_vec( 6, T_RD,  32'h0008, 2'd1, 32'h0,        32'h000000ef);
    set_vec( 7, T_RD,  32'h0009, 2'd1, 32'h0,        32'h0000000c);
    set_vec( 8, T_RD,  32'h000a, 2'd1, 32'h0,        32'h0000000b);
    set_vec( 9, T_RD,  32'h000b, 2'd1, 32'h0,        32'h0000000a);
    set_vec(10, T_WR,  32'h000c, 2'd0, 32'h01020304, 32'h0);
    set_vec(11, T_WR,  32'h000c, 2'd2, 32'hdeadbeef, 32'h0);
    set_vec(12, T_RD,  32'h000c, 2'd2, 32'h0,        32'h0000beef);
    set_vec(13, T_RD,  32'h000e, 2'd2, 32'h0,        32'h00000102);
    set_vec(14, T_WR,  32'h0014, 2'd0, 32'ha0b0c0d0, 32'h0);
    set_vec(15, T_WR,  32'h1014, 2'd0, 32'he0102030, 32'h0);
    set_vec(16, T_RD,  32'h0014, 2'd0, 32'h0,        32'he0102030);
    set_vec(17, T_RD,  32'h1014, 2'd0, 32'h0,        32'he0102030);
    set_vec(18, T_OR,  32'h0000, 2'd0, 32'hf0f0f0f0, 32'h0a0b0c0d);
    set_vec(19, T_RD,  32'h0000, 2'd0, 32'h0,        32'hfafbfcfd);
    set_vec(20, T_ADD, 32'h0004, 2'd0, 32'h00000fff, 32'h0e0f0102);
    set_vec(21, T_RD,  32'h0004, 2'd0, 32'h0,        32'h0e0f1101);
    set_vec(22, T_AND, 32'h0000, 2'd0, 32'h33333333, 32'hfafbfcfd);
    set_vec(23, T_RD,  32'h0000, 2'd0, 32'h0,        32'h32333031);

    reset = 1'b1; mem_clear = 1'b0; max_delay = 32'd0;
    memreq_val = 1'b0; memreq_msg = '0; memresp_rdy = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_req_rdy", 64'(memreq_rdy), 64'd0);
    check("reset_resp_val", 64'(memresp_val), 64'd0);
    reset = 1'b0; #1;
    check("post_reset_req_rdy", 64'(memreq_rdy), 64'd1);
    check("post_reset_resp_val", 64'(memresp_val), 64'd0);
    @(posedge clk); #1;

    // Zero delays: full table, one message per cycle
    run_cfg(0, 0, 0, dur);
    check("throughput_0_0_0", 64'(dur <= 30), 64'd1);

    run_cfg(3, 0, 10, dur);
    run_cfg(10, 0, 3, dur);
    run_cfg(0, 5, 0, dur);
    run_cfg(3, 5, 10, dur);
    run_cfg(10, 5, 3, dur);

    // Back-pressure hold, then asynchronous reset with a response pending
    max_delay = 32'd0; memresp_rdy = 1'b0;
    memreq_val = 1'b1; memreq_msg = {T_RD, 8'h55, 32'h0, 2'd0, 32'h0};
    @(negedge clk);
    check("hold_req_rdy_empty", 64'(memreq_rdy), 64'd1);
    @(posedge clk); #1; memreq_val = 1'b0;
    @(negedge clk);
    check("hold_resp_val", 64'(memresp_val), 64'd1);
    check("hold_resp_msg", 64'(memresp_msg), 64'({T_RD, 8'h55, 2'd0, 32'h32333031}));
    check("hold_req_rdy_full", 64'(memreq_rdy), 64'd0);
    @(posedge clk); #1; @(negedge clk);
    check("hold_resp_val2", 64'(memresp_val), 64'd1);
    check("hold_resp_msg2", 64'(memresp_msg), 64'({T_RD, 8'h55, 2'd0, 32'h32333031}));
    reset = 1'b1; #1;
    check("midreset_resp_val", 64'(memresp_val), 64'd0);
    check("midreset_req_rdy", 64'(memreq_rdy), 64'd0);
    @(posedge clk); #1;
    check("midreset_req_rdy_edge", 64'(memreq_rdy), 64'd0);
    @(negedge clk); reset = 1'b0; #1;
    check("midreset_release_rdy", 64'(memreq_rdy), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midreset_discarded", 64'(memresp_val), 64'd0);
    @(posedge clk); #1;

    // Delay bound: valid within max_delay+1 cycles of accept
    max_delay = 32'd10; memresp_rdy = 1'b0;
    memreq_val = 1'b1; memreq_msg = {T_RD, 8'h66, 32'h4, 2'd0, 32'h0};
    @(negedge clk);
    check("delay_req_rdy", 64'(memreq_rdy), 64'd1);
    @(posedge clk); #1; memreq_val = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk); lat++;
      if (memresp_val) break;
      @(posedge clk); #1;
    end
    $display("delay test: latency %0d cycles", lat);
    check("delay_latency_bound", 64'(lat >= 1 && lat <= 11), 64'd1);
    check("delay_resp_msg", 64'(memresp_msg), 64'({T_RD, 8'h66, 2'd0, 32'h0e0f1101}));
    memresp_rdy = 1'b1;
    @(posedge clk); #1; @(negedge clk);
    check("delay_drained", 64'(memresp_val), 64'd0);
    @(posedge clk); #1;

    // Clear concurrent with an accepted write: clear wins
    max_delay = 32'd0;
    mem_clear = 1'b1;
    xact({T_WR, 8'h70, 32'h20, 2'd0, 32'hffffffff}, {T_WR, 8'h70, 2'd0, 32'h0}, "clear_wr");
    mem_clear = 1'b0;
    xact({T_RD, 8'h71, 32'h20, 2'd0, 32'h0}, {T_RD, 8'h71, 2'd0, 32'h0}, "clear_rd20");
    xact({T_RD, 8'h72, 32'h0, 2'd0, 32'h0},  {T_RD, 8'h72, 2'd0, 32'h0}, "clear_rd0");
    xact({T_WR, 8'h73, 32'h3fe, 2'd0, 32'h11223344}, {T_WR, 8'h73, 2'd0, 32'h0}, "wrap_wr");
    xact({T_RD, 8'h74, 32'h0, 2'd2, 32'h0}, {T_RD, 8'h74, 2'd2, 32'h00001122}, "wrap_rd0");
    xact({T_RD, 8'h75, 32'h3fe, 2'd0, 32'h0}, {T_RD, 8'h75, 2'd0, 32'h11223344}, "wrap_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
